mips16_ctrl: RTL and testbench

// Multicycle control FSM for the 16-bit MIPS datapath; the initiator side of the ALU interface.

---
 rtl/mips16_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_mips16_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips16_ctrl.sv
// Multicycle control FSM for the 16-bit MIPS datapath; drives ALU selects and datapath strobes.
// Optional feature: define MIPS16_CTRL_SLT_EN to decode op 0x0 with IR[11:0]!=0 as SLT.
module mips16_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic [3:0]  alu_mode,
    output logic        alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [15:0] imm_ext,
    output logic [3:0]  rf_ra1,
    output logic [3:0]  rf_ra2,
    output logic [3:0]  rf_wa,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        ab_we,
    output logic        aluout_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        halt,
    output logic        err,
    output logic [2:0]  state_o
);
    localparam int unsigned CNT_W = 16;
    localparam logic [3:0] OP_ADDI = 4'hC;
    localparam logic [3:0] OP_LW   = 4'hD;
    localparam logic [3:0] OP_SW   = 4'hE;
    localparam logic [3:0] OP_BEQ  = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t           state;
    state_t           ns;
    logic [15:0]      ir;
    logic [3:0]       op;
    logic             zero_q;
    logic             fetch_q;
    logic             load_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             waiting;
    logic             to_err;
    logic             tmo_hit;
    logic             is_halt;

    assign op      = ir[15:12];
    assign imm_ext = {{12{ir[3]}}, ir[3:0]};
    assign rf_ra1  = ir[7:4];
    assign rf_ra2  = (op == OP_SW || op == OP_BEQ) ? ir[11:8] : ir[3:0];
    assign rf_wa   = ir[11:8];
    assign state_o = state;

    // Load strobes that complete with the memory handshake; fetch_q/load_q are registered
    assign pc_we  = rst_n & ((fetch_q & mem_ready) | ((state == S_BRANCH) & zero_q));
    assign mdr_we = rst_n & load_q & mem_ready;

`ifdef MIPS16_CTRL_SLT_EN
    assign is_halt = (ir == 16'h0000);
`else
    assign is_halt = (op == 4'h0);
`endif

    assign tmo_hit = (MEM_TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) >= MEM_TIMEOUT);

    // Next-state selection; FETCH only progresses once its read strobe is actually up
    always_comb begin
        ns      = state;
        waiting = 1'b0;
        to_err  = 1'b0;
        case (state)
            S_FETCH: begin
                if (fetch_q) begin
                    if (mem_ready) begin
                        ns = S_DECODE;
                    end else begin
                        waiting = 1'b1;
                        if (tmo_hit) begin
                            ns     = S_HALT;
                            to_err = 1'b1;
                        end
                    end
                end
            end
            S_DECODE: ns = is_halt ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (op == OP_LW || op == OP_SW) ns = S_MEM;
                else if (op == OP_BEQ)          ns = S_BRANCH;
                else                            ns = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    ns = (op == OP_LW) ? S_WB : S_FETCH;
                end else begin
                    waiting = 1'b1;
                    if (tmo_hit) begin
                        ns     = S_HALT;
                        to_err = 1'b1;
                    end
                end
            end
            S_WB, S_BRANCH: ns = S_FETCH;
            S_HALT:         ns = S_HALT;
            default:        ns = S_HALT;
        endcase
    end

    // State, IR, flags and outputs registered as a decode of the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            ir           <= '0;
            zero_q       <= 1'b0;
            wait_cnt     <= '0;
            err          <= 1'b0;
            fetch_q      <= 1'b0;
            load_q       <= 1'b0;
            alu_mode     <= 4'h0;
            alu_a_sel    <= 1'b0;
            alu_b_sel    <= 2'd0;
            rf_we        <= 1'b0;
            wb_sel       <= 1'b0;
            ab_we        <= 1'b0;
            aluout_we    <= 1'b0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            halt         <= 1'b0;
        end else begin
            state <= ns;
            if (state == S_FETCH && fetch_q && mem_ready) ir <= mem_rdata;
            if (state == S_EXEC && op == OP_BEQ) zero_q <= alu_zero;
            if (ns != state)  wait_cnt <= '0;
            else if (waiting) wait_cnt <= wait_cnt + CNT_W'(1);
            err <= err | to_err;

            fetch_q      <= 1'b0;
            load_q       <= 1'b0;
            alu_mode     <= 4'h0;
            alu_a_sel    <= 1'b0;
            alu_b_sel    <= 2'd0;
            rf_we        <= 1'b0;
            wb_sel       <= 1'b0;
            ab_we        <= 1'b0;
            aluout_we    <= 1'b0;
            mem_re       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr_sel <= 1'b0;
            halt         <= 1'b0;
            case (ns)
                S_FETCH: begin
                    fetch_q   <= 1'b1;
                    mem_re    <= 1'b1;
                    alu_mode  <= 4'h1;
                    alu_b_sel <= 2'd1;
                end
                S_DECODE: ab_we <= 1'b1;
                S_EXEC: begin
                    aluout_we <= 1'b1;
                    alu_a_sel <= 1'b1;
                    if (op == OP_BEQ) begin
                        alu_mode <= 4'h2;
                    end else if (op >= OP_ADDI) begin
                        alu_mode  <= 4'h1;
                        alu_b_sel <= 2'd2;
                    end else if (op == 4'h0) begin
                        alu_mode <= 4'hF;
                    end else begin
                        alu_mode <= op;
                    end
                end
                S_MEM: begin
                    mem_addr_sel <= 1'b1;
                    if (op == OP_LW) begin
                        mem_re <= 1'b1;
                        load_q <= 1'b1;
                    end else begin
                        mem_we <= 1'b1;
                    end
                end
                S_WB: begin
                    rf_we  <= (ir[11:8] != 4'h0);
                    wb_sel <= (op == OP_LW);
                end
                S_BRANCH: begin
                    alu_mode  <= 4'h1;
                    alu_b_sel <= 2'd2;
                end
                S_HALT:  halt <= 1'b1;
                default: halt <= 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_mips16_ctrl.sv
// Self-checking bench for mips16_ctrl: per-cycle expected outputs queued from an instruction model.
module tb_mips16_ctrl;
`ifdef MIPS16_CTRL_SLT_EN
    localparam bit SLT = 1'b1;
`else
    localparam bit SLT = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  st;
        logic [3:0]  mode;
        logic        a;
        logic [1:0]  b;
        logic        mem_re;
        logic        mem_we;
        logic        addr_sel;
        logic        pc_we;
        logic        ab_we;
        logic        aluout_we;
        logic        mdr_we;
        logic        rf_we;
        logic        wb_sel;
        logic        halt;
        logic        err;
        logic [3:0]  ra1;
        logic [3:0]  ra2;
        logic [3:0]  wa;
        logic [15:0] imm;
    } snap_t;

    typedef struct packed {
        logic        rdy;
        logic [15:0] rdata;
        logic        zero;
        snap_t       exp;
    } cyc_t;

    typedef struct {
        logic [15:0] ins;
        logic        z;
        int          fw;
        int          mw;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic mem_ready = 1'b0;
    logic alu_zero = 1'b0;
    logic [3:0] alu_mode, rf_ra1, rf_ra2, rf_wa;
    logic alu_a_sel, rf_we, wb_sel, ab_we, aluout_we, mdr_we, pc_we;
    logic mem_re, mem_we, mem_addr_sel, halt, err;
    logic [1:0] alu_b_sel;
    logic [15:0] imm_ext;
    logic [2:0] state_o;

    logic [15:0] t_rdata = 16'h1234;
    logic t_ready = 1'b0;
    logic t_zero = 1'b0;
    logic [3:0] t_mode, t_ra1, t_ra2, t_wa;
    logic t_a_sel, t_rf_we, t_wb_sel, t_ab_we, t_aluout_we, t_mdr_we, t_pc_we;
    logic t_mem_re, t_mem_we, t_addr_sel, t_halt, t_err;
    logic [1:0] t_b_sel;
    logic [15:0] t_imm;
    logic [2:0] t_state;

    int total = 0;
    int bad = 0;
    cyc_t q[$];
    logic [15:0] cur_ir = '0;
    logic t_pc_seen = 1'b0;

    always #5 clk = ~clk;

    mips16_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .alu_mode(alu_mode), .alu_a_sel(alu_a_sel),
        .alu_b_sel(alu_b_sel), .imm_ext(imm_ext), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2),
        .rf_wa(rf_wa), .rf_we(rf_we), .wb_sel(wb_sel), .ab_we(ab_we),
        .aluout_we(aluout_we), .mdr_we(mdr_we), .pc_we(pc_we), .mem_re(mem_re),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .halt(halt), .err(err),
        .state_o(state_o)
    );

    mips16_ctrl #(.MEM_TIMEOUT(4)) u_tmo (
        .clk(clk), .rst_n(rst_n), .mem_rdata(t_rdata), .mem_ready(t_ready),
        .alu_zero(t_zero), .alu_mode(t_mode), .alu_a_sel(t_a_sel),
        .alu_b_sel(t_b_sel), .imm_ext(t_imm), .rf_ra1(t_ra1), .rf_ra2(t_ra2),
        .rf_wa(t_wa), .rf_we(t_rf_we), .wb_sel(t_wb_sel), .ab_we(t_ab_we),
        .aluout_we(t_aluout_we), .mdr_we(t_mdr_we), .pc_we(t_pc_we), .mem_re(t_mem_re),
        .mem_we(t_mem_we), .mem_addr_sel(t_addr_sel), .halt(t_halt), .err(t_err),
        .state_o(t_state)
    );

    always @(negedge clk) if (t_pc_we === 1'b1) t_pc_seen = 1'b1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic snap_t act_snap();
        snap_t s;
        s.st = state_o;        s.mode = alu_mode;        s.a = alu_a_sel;
        s.b = alu_b_sel;       s.mem_re = mem_re;        s.mem_we = mem_we;
        s.addr_sel = mem_addr_sel; s.pc_we = pc_we;      s.ab_we = ab_we;
        s.aluout_we = aluout_we;   s.mdr_we = mdr_we;    s.rf_we = rf_we;
        s.wb_sel = wb_sel;     s.halt = halt;            s.err = err;
        s.ra1 = rf_ra1;        s.ra2 = rf_ra2;           s.wa = rf_wa;
        s.imm = imm_ext;
        return s;
    endfunction

    // Field wiring of the held instruction, all strobes idle
    function automatic snap_t base(input logic [15:0] ir);
        snap_t s;
        s = '0;
        s.ra1 = ir[7:4];
        s.ra2 = (ir[15:12] == 4'hE || ir[15:12] == 4'hF) ? ir[11:8] : ir[3:0];
        s.wa  = ir[11:8];
        s.imm = {{12{ir[3]}}, ir[3:0]};
        return s;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic r, input logic [15:0] d, input logic z, input snap_t e);
        cyc_t c;
        c.rdy = r; c.rdata = d; c.zero = z; c.exp = e;
        q.push_back(c);
    endtask

    // Expected per-cycle outputs for one instruction; cut stops after the first MEM wait cycle
    task automatic push_instr(input logic [15:0] ins, input logic z, input int fw, input int mw,
                              input bit cut);
        snap_t s;
        logic [3:0] op;
        op = ins[15:12];
        for (int i = 0; i <= fw; i++) begin
            s = base(cur_ir); s.st = 3'd0; s.mem_re = 1'b1; s.mode = 4'h1; s.b = 2'd1;
            s.pc_we = (i == fw);
            push(i == fw, (i == fw) ? ins : 16'($urandom), rb(), s);
        end
        cur_ir = ins;
        s = base(ins); s.st = 3'd1; s.ab_we = 1'b1;
        push(rb(), 16'($urandom), rb(), s);
        if (op == 4'h0 && (!SLT || ins == 16'h0000)) begin
            for (int i = 0; i < 20; i++) begin
                s = base(ins); s.st = 3'd6; s.halt = 1'b1;
                push(rb(), 16'($urandom), rb(), s);
            end
            return;
        end
        s = base(ins); s.st = 3'd2; s.aluout_we = 1'b1; s.a = 1'b1;
        if (op == 4'h0)      begin s.mode = 4'hF; s.b = 2'd0; end
        else if (op <= 4'hB) begin s.mode = op;   s.b = 2'd0; end
        else if (op == 4'hF) begin s.mode = 4'h2; s.b = 2'd0; end
        else                 begin s.mode = 4'h1; s.b = 2'd2; end
        push(rb(), 16'($urandom), (op == 4'hF) ? z : rb(), s);
        if (op == 4'hF) begin
            s = base(ins); s.st = 3'd5; s.mode = 4'h1; s.b = 2'd2; s.pc_we = z;
            push(rb(), 16'($urandom), rb(), s);
            return;
        end
        if (op == 4'hD || op == 4'hE) begin
            for (int i = 0; i <= mw; i++) begin
                s = base(ins); s.st = 3'd3; s.addr_sel = 1'b1;
                if (op == 4'hD) begin s.mem_re = 1'b1; s.mdr_we = (i == mw); end
                else            s.mem_we = 1'b1;
                push((i == mw) && !cut, 16'($urandom), rb(), s);
                if (cut) return;
            end
            if (op == 4'hE) return;
        end
        s = base(ins); s.st = 3'd4; s.rf_we = (ins[11:8] != 4'h0); s.wb_sel = (op == 4'hD);
        push(rb(), 16'($urandom), rb(), s);
    endtask

    task automatic run_q();
        cyc_t c;
        int n;
        n = 0;
        while (q.size() != 0) begin
            c = q.pop_front();
            @(negedge clk);
            mem_ready = c.rdy; mem_rdata = c.rdata; alu_zero = c.zero;
            #1;
            check($sformatf("cyc%0d st%0d ir%h", n, c.exp.st, cur_ir), 64'(act_snap()), 64'(c.exp));
            n++;
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst_n = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check(name, 64'(act_snap()), 64'(snap_t'('0)));
        rst_n = 1'b1; mem_ready = 1'b0;
        cur_ir = '0;
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{16'h1123, 1'b0, 0, 0});
        tbl.push_back('{16'hD21F, 1'b0, 1, 3});
        tbl.push_back('{16'hF12E, 1'b1, 0, 0});
        tbl.push_back('{16'hF12E, 1'b0, 2, 0});
        tbl.push_back('{16'hC30A, 1'b0, 0, 0});
        tbl.push_back('{16'hE450, 1'b0, 0, 2});
        tbl.push_back('{16'hB0CD, 1'b0, 1, 0});
        tbl.push_back('{16'h5567, 1'b1, 0, 0});
`ifdef MIPS16_CTRL_SLT_EN
        tbl.push_back('{16'h0123, 1'b0, 0, 0});
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset main", 64'(act_snap()), 64'(snap_t'('0)));
        check("reset tmo", 64'({t_halt, t_err, t_mem_re, t_pc_we, t_state}), 64'(0));
        rst_n = 1'b1;

        // Timeout instance never sees mem_ready: four wait cycles then halt with err
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("tmo n%0d", i), 64'({t_halt, t_err, t_mem_re}),
                  (i < 5) ? 64'(3'b001) : 64'(3'b110));
            if (i == 1) check("first fetch", 64'({mem_re, mem_addr_sel, state_o}), 64'(5'b10000));
        end

        foreach (tbl[i]) begin
            push_instr(tbl[i].ins, tbl[i].z, tbl[i].fw, tbl[i].mw, 1'b0);
            run_q();
        end

        push_instr(16'h0000, 1'b0, 0, 0, 1'b0);
        run_q();
        do_reset("reset from halt");
        push_instr(16'h1123, 1'b0, 0, 0, 1'b0);
        run_q();

        push_instr(16'hE450, 1'b0, 0, 0, 1'b1);
        run_q();
        do_reset("reset mid store");
        push_instr(16'h5567, 1'b0, 1, 0, 1'b0);
        run_q();

        check("tmo pc_we never", 64'(t_pc_seen), 64'(0));
        check("tmo sticky", 64'({t_halt, t_err}), 64'(2'b11));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
